// File: rtl/rr_mux_n_ch.sv
// rr_mux_n_ch: arbitrates CH input channels onto a single registered output.
// MODE 0 rotates priority after each grant; MODE 1 is fixed priority with
// channel 0 highest. The output register accepts a new word whenever it is
// empty or is being drained in the same cycle.
module rr_mux_n_ch #(
  parameter int N    = 4,
  parameter int CH   = 4,
  parameter int MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*N-1:0]   in_data,
  output logic [CH-1:0]     in_ready,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output logic [$clog2(CH)-1:0] out_ch,
  input  logic              out_ready
);

  localparam int SW = $clog2(CH);
  localparam logic [SW:0]   CH_W = (SW+1)'(CH);
  localparam logic [SW-1:0] LAST = SW'(CH - 1);

  logic [SW-1:0] ptr;
  logic          load_en;
  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic [SW:0]   cand;
  logic          grant;
  logic [N-1:0]  sel_data;

  assign load_en = !out_valid || out_ready;
  // Reset blocks every grant so nothing is accepted while rst_n is low.
  assign grant   = rst_n && load_en && grant_found;

  // Search upward from ptr, wrapping at CH so indices >= CH are never produced.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < CH; k++) begin
      cand = {1'b0, ptr} + (SW+1)'(k);
      if (cand >= CH_W) begin
        cand = cand - CH_W;
      end
      if (!grant_found && in_valid[cand[SW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SW-1:0];
      end
    end
  end

  // One-hot accept for the granted channel only; independent of in_data.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CH; i++) begin
      in_ready[i] = grant && (grant_idx == SW'(i));
    end
  end

  // Select the granted channel's word for loading into the output register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_idx == SW'(i)) begin
        sel_data = in_data[i*N +: N];
      end
    end
  end

  // Output register and rotating pointer; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= grant_idx;
        if (MODE == 0) begin
          if (grant_idx == LAST) begin
            ptr <= '0;
          end else begin
            ptr <= grant_idx + 1'b1;
          end
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
